// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate for one neuron pre-activation.
// z = bias + sum(x[i] * w[i]) in signed Q8.24. The result is saturated to
// 32 bits and held on z_out until the downstream sigmoid consumer takes it.
module neuron_mac #(
    parameter int N_INPUTS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [31:0] bias,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] x_in,
    input  logic signed [31:0] w_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] z_out,
    output logic               ovf,
    output logic               busy
);

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;
    localparam int ACC_W  = 48;
    localparam int FRAC   = 24;
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] OUTPUT = 2'd2;

    logic [1:0]               state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W:0]          sat_res;
    logic                     accept;
    logic                     last_beat;

    // Clamp the wide accumulator into Q8.24; top bit of the result flags saturation.
    function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > hi)
            return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        else if (v < lo)
            return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, v[DATA_W-1:0]};
    endfunction

    // Handshake outputs decode straight from the state register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);

    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (count == CNT_W'(N_INPUTS - 1));

    // Full-precision product, then floor back to Q8.24 (arithmetic shift, no rounding).
    assign prod     = PROD_W'(x_in) * PROD_W'(w_in);
    assign term     = ACC_W'(prod >>> FRAC);
    assign acc_next = acc + term;
    assign sat_res  = saturate(acc_next);

    // Control FSM, accumulator and registered result; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            z_out <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= ACC_W'(bias);
                        count <= '0;
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        if (last_beat) begin
                            count <= '0;
                            z_out <= sat_res[DATA_W-1:0];
                            ovf   <= sat_res[DATA_W];
                            state <= OUTPUT;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed and randomized checks of neuron_mac against a
// floor-division reference model of the neuron sum.
module tb_neuron_mac;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x_in = '0;
    logic [31:0] w_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] z_out;
    logic        ovf;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] xs [N];
    logic [31:0] ws [N];

    neuron_mac #(.N_INPUTS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_out     (z_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: bias + sum of floor(x*w / 2^24), then clamp to the signed 32-bit range.
    function automatic logic [32:0] model(input logic [31:0] b);
        longint d = 64'sd16777216;
        longint hi = 64'sd2147483647;
        longint lo = -64'sd2147483648;
        longint s;
        longint p;
        longint q;
        s = longint'($signed(b));
        for (int i = 0; i < N; i++) begin
            p = longint'($signed(xs[i])) * longint'($signed(ws[i]));
            q = p / d;
            if (p < 0 && (p % d) != 0) q = q - 1;
            s = s + q;
        end
        if (s > hi) return {1'b1, 32'h7FFFFFFF};
        if (s < lo) return {1'b1, 32'h80000000};
        return {1'b0, s[31:0]};
    endfunction

    // One complete neuron: start, N beats with 'gap' idle cycles before each,
    // then hold out_ready low for 'ogap' cycles (optionally pulsing a stray start).
    task automatic run_neuron(input string tag, input logic [31:0] b, input int gap,
                              input int ogap, input bit stray,
                              input logic [31:0] exp_z, input logic exp_ovf);
        bias  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        bias  = $urandom;
        chk({tag, ".in_ready_after_start"}, 32'(in_ready), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b0;
            x_in = $urandom;
            w_in = $urandom;
            for (int g = 0; g < gap; g++) tick();
            in_valid = 1'b1;
            x_in = xs[i];
            w_in = ws[i];
            tick();
        end
        in_valid = 1'b0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".in_ready_in_output"}, 32'(in_ready), 32'd0);
        chk({tag, ".z_out"}, z_out, exp_z);
        chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        for (int j = 0; j < ogap; j++) begin
            if (stray && j == 1) begin
                start = 1'b1;
                bias  = 32'h12345678;
            end
            in_valid = 1'b1;
            tick();
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_z"}, z_out, exp_z);
            chk({tag, ".hold_ovf"}, 32'(ovf), 32'(exp_ovf));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk({tag, ".out_valid_cleared"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle_after_output"}, 32'(busy), 32'd0);
    endtask

    task automatic load_nominal();
        xs[0] = 32'h01000000; ws[0] = 32'h00800000;
        xs[1] = 32'h00800000; ws[1] = 32'h00800000;
        xs[2] = 32'hFF000000; ws[2] = 32'h00800000;
        xs[3] = 32'h02000000; ws[3] = 32'h00400000;
    endtask

    initial begin
        logic [32:0] m;

        // Reset state
        #2;
        chk("reset.z_out", z_out, 32'd0);
        chk("reset.ovf", 32'(ovf), 32'd0);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Nominal, no stalls
        load_nominal();
        run_neuron("nominal", 32'd0, 0, 0, 1'b0, 32'h00C00000, 1'b0);

        // Positive and negative saturation
        for (int i = 0; i < N; i++) begin xs[i] = 32'h64000000; ws[i] = 32'h02000000; end
        run_neuron("sat_pos", 32'd0, 0, 0, 1'b0, 32'h7FFFFFFF, 1'b1);
        for (int i = 0; i < N; i++) ws[i] = 32'hFE000000;
        run_neuron("sat_neg", 32'd0, 0, 0, 1'b0, 32'h80000000, 1'b1);

        // Truncation toward minus infinity
        xs[0] = 32'h00000001; ws[0] = 32'h00000001;
        xs[1] = 32'hFFFFFFFF; ws[1] = 32'h00000001;
        xs[2] = 32'd0;        ws[2] = 32'h00000001;
        xs[3] = 32'd0;        ws[3] = 32'h00000001;
        run_neuron("trunc", 32'd0, 0, 0, 1'b0, 32'hFFFFFFFF, 1'b0);

        // Handshake stalls plus stray start during OUTPUT
        load_nominal();
        run_neuron("stall", 32'd0, 3, 5, 1'b1, 32'h00C00000, 1'b0);

        // in_valid in IDLE consumes nothing; result is bias only
        x_in = 32'h7FFFFFFF; w_in = 32'h7FFFFFFF; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle.in_ready", 32'(in_ready), 32'd0);
            chk("idle.busy", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin xs[i] = 32'd0; ws[i] = $urandom; end
        run_neuron("bias", 32'h00800000, 0, 0, 1'b0, 32'h00800000, 1'b0);

        // Reset after 2 of 4 beats, z_out still holds the previous result
        load_nominal();
        run_neuron("pre_rst", 32'd0, 0, 2, 1'b0, 32'h00C00000, 1'b0);
        start = 1'b1; bias = 32'h01000000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; x_in = xs[i]; w_in = ws[i];
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.z_out", z_out, 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_neuron("post_rst", 32'd0, 0, 0, 1'b0, 32'h00C00000, 1'b0);

        // Randomized neurons against the reference model
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = $urandom;
                ws[i] = $urandom;
                if (k % 3 != 0) begin
                    xs[i] = 32'($signed(xs[i]) >>> 6);
                    ws[i] = 32'($signed(ws[i]) >>> 6);
                end
            end
            bias = $urandom;
            m = model(bias);
            run_neuron("random", bias, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       1'b1, m[31:0], m[32]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
